// File: rtl/tri_sweep_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tri_sweep_seq                                                            |
// | Steps a triangle generator through NUM_STEPS power-of-two increments.    |
// | Optional button debounce: define TRI_SWEEP_DEBOUNCE_EN.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tri_sweep_seq #(
    parameter int NUM_STEPS       = 4,
    parameter int CYCLES_PER_STEP = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       GCLK,
    input  logic       RSTN,
    input  logic       BTNU,
    input  logic       BTND,
    output logic       cfg_valid,
    input  logic       cfg_ready,
    output logic [7:0] cfg_step,
    output logic       gen_en,
    input  logic       gen_cycle_done,
    output logic [7:0] LD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] c_LAST_IDX = 3'(NUM_STEPS - 1);
    localparam logic [7:0] c_LAST_CYC = 8'(CYCLES_PER_STEP - 1);

    if (NUM_STEPS < 2 || NUM_STEPS > 8 || CYCLES_PER_STEP < 1 ||
        CYCLES_PER_STEP > 255 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("tri_sweep_seq: parameter out of range");
    end

    // bit 0 = BTNU (start), bit 1 = BTND (stop)
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_btn_prev;
    logic [1:0] w_btn_clean;

    always_ff @(posedge GCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sync1    <= 2'b00;
            r_sync2    <= 2'b00;
            r_btn_prev <= 2'b00;
        end else begin
            r_sync1    <= {BTND, BTNU};
            r_sync2    <= r_sync1;
            r_btn_prev <= w_btn_clean;
        end
    end

`ifdef TRI_SWEEP_DEBOUNCE_EN
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar g = 0; g < 2; g++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_stable;

        // a new level is adopted only after DEBOUNCE_CYCLES samples in a row
        always_ff @(posedge GCLK or negedge RSTN) begin
            if (!RSTN) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[g] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt    <= '0;
                r_stable <= r_sync2[g];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_btn_clean[g] = r_stable;
    end
`else
    assign w_btn_clean = r_sync2;
`endif

    logic w_start_p;
    logic w_stop_p;
    logic w_stop_any;

    assign w_start_p  = w_btn_clean[0] & ~r_btn_prev[0];
    assign w_stop_p   = w_btn_clean[1] & ~r_btn_prev[1];

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nx;
    logic [7:0] r_cyc;
    logic [7:0] w_cyc_nx;
    logic       r_stop_pend;
    logic       w_stop_pend_nx;

    assign w_stop_any = r_stop_pend | w_stop_p;

    always_ff @(posedge GCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_cyc       <= 8'd0;
            r_stop_pend <= 1'b0;
            cfg_valid   <= 1'b0;
            gen_en      <= 1'b0;
            cfg_step    <= 8'h01;
            LD          <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_cyc       <= w_cyc_nx;
            r_stop_pend <= w_stop_pend_nx;
            // outputs are decoded from the next state so they line up with r_state
            cfg_valid   <= (w_state_nx == S_LOAD);
            gen_en      <= (w_state_nx == S_RUN) || (w_state_nx == S_DRAIN);
            cfg_step    <= 8'h01 << w_idx_nx;
            LD          <= {w_state_nx, w_idx_nx, w_cyc_nx[2:0]};
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_cyc_nx       = r_cyc;
        w_stop_pend_nx = w_stop_any;

        case (r_state)
            S_IDLE: begin
                if (w_start_p && !w_stop_p) begin
                    w_state_nx = S_LOAD;
                    w_idx_nx   = 3'd0;
                end
            end
            S_LOAD: begin
                // a pending stop waits for the handshake; the offer is never withdrawn
                if (cfg_ready) begin
                    w_cyc_nx   = 8'd0;
                    w_state_nx = w_stop_any ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (gen_cycle_done) begin
                    w_cyc_nx = r_cyc + 8'd1;
                end
                if (w_stop_any) begin
                    w_state_nx = gen_cycle_done ? S_IDLE : S_DRAIN;
                end else if (gen_cycle_done && r_cyc == c_LAST_CYC) begin
                    w_state_nx = S_LOAD;
                    w_idx_nx   = (r_idx == c_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                end
            end
            S_DRAIN: begin
                if (gen_cycle_done) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_state_nx == S_IDLE) begin
            w_stop_pend_nx = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tri_sweep_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tri_sweep_seq                                                         |
// | Randomized scoreboard bench for tri_sweep_seq.                           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tri_sweep_seq;

    localparam int NS  = 4;
    localparam int CPS = 8;
    localparam int DB  = 4;

    logic       GCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       BTNU = 1'b0;
    logic       BTND = 1'b0;
    logic       cfg_ready = 1'b0;
    logic       gen_cycle_done = 1'b0;
    logic       cfg_valid;
    logic       gen_en;
    logic [7:0] cfg_step;
    logic [7:0] LD;

    tri_sweep_seq #(
        .NUM_STEPS      (NS),
        .CYCLES_PER_STEP(CPS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .GCLK          (GCLK),
        .RSTN          (RSTN),
        .BTNU          (BTNU),
        .BTND          (BTND),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_step      (cfg_step),
        .gen_en        (gen_en),
        .gen_cycle_done(gen_cycle_done),
        .LD            (LD)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        logic [7:0] step;
        int         pulses;   // -1: first entry of a session, count not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model of the sweep: entry k of a session uses 1 << (k mod NS)
    bit m_active   = 1'b0;
    bit m_stopping = 1'b0;
    int m_k        = 0;
    int m_pulses   = 0;

    bit gen_allow  = 1'b1;
    bit noise_en   = 1'b1;
    bit hold_ready = 1'b0;
    bit bp_once    = 1'b0;
    int wait_max   = 0;
    int rdy_wait   = 0;
    int gap        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_step(input int k);
        int e;
        e = k % NS;
        return 8'(1 << e);
    endfunction

    task automatic push_entry(input int pulses);
        exp_t e;
        e.step   = ref_step(m_k);
        e.pulses = pulses;
        exp_q.push_back(e);
    endtask

    task automatic model_pulse();
        if (m_active) begin
            if (m_stopping) begin
                m_active = 1'b0;
            end else begin
                m_pulses++;
                if (m_pulses == CPS) begin
                    m_pulses = 0;
                    m_k++;
                    push_entry(CPS);
                end
            end
        end
    endtask

    // one clock of the generator/consumer model, driven at the falling edge
    task automatic step_cycle();
        @(negedge GCLK);
        if (cfg_valid) begin
            if (hold_ready) begin
                cfg_ready = 1'b0;
            end else if (rdy_wait == 0) begin
                cfg_ready = 1'b1;
                bp_once   = 1'b0;
            end else begin
                cfg_ready = 1'b0;
                rdy_wait--;
            end
        end else begin
            cfg_ready = 1'($urandom_range(0, 1));
            rdy_wait  = bp_once ? 20 : $urandom_range(0, wait_max);
        end
        gen_cycle_done = 1'b0;
        if (gen_en) begin
            if (gen_allow) begin
                if (gap == 0) begin
                    gen_cycle_done = 1'b1;
                    gap = $urandom_range(0, 3);
                    model_pulse();
                end else begin
                    gap--;
                end
            end
        end else if (noise_en && $urandom_range(0, 7) == 0) begin
            gen_cycle_done = 1'b1;
        end
    endtask

    task automatic hold_button(input bit u, input bit d);
        BTNU = u;
        BTND = d;
        repeat (2 * DB + 6) step_cycle();
        BTNU = 1'b0;
        BTND = 1'b0;
        repeat (2 * DB + 6) step_cycle();
    endtask

    task automatic start_session();
        m_active   = 1'b1;
        m_stopping = 1'b0;
        m_k        = 0;
        m_pulses   = 0;
        push_entry(-1);
        hold_button(1'b1, 1'b0);
    endtask

    task automatic run_until_k(input int k);
        int b;
        b = 0;
        while (m_k < k && b < 3000) begin
            step_cycle();
            b++;
        end
        check("entries_reached", m_k, k);
    endtask

    task automatic wait_run();
        int b;
        b = 0;
        step_cycle();
        while (!(gen_en && !cfg_valid) && b < 200) begin
            step_cycle();
            b++;
        end
        check("wait_run_timeout", (b < 200), 1);
    endtask

    task automatic finish_drain();
        int b;
        b = 0;
        gen_allow = 1'b1;
        while (m_active && b < 200) begin
            step_cycle();
            b++;
        end
        check("drain_timeout", m_active, 0);
        step_cycle();
        check("idle_gen_en", gen_en, 0);
        check("idle_state", LD[7:6], 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic stop_in_run();
        gen_allow = 1'b0;
        wait_run();
        m_stopping = 1'b1;
        hold_button(1'b0, 1'b1);
        check("drain_gen_en", gen_en, 1);
        check("drain_state", LD[7:6], 3);
        finish_drain();
    endtask

    // monitor: handshakes against the expectation queue, plus protocol properties
    initial begin
        bit         pw;
        logic [7:0] ps;
        int         pc;
        exp_t       e;
        pw = 1'b0;
        ps = 8'h00;
        pc = 0;
        forever begin
            @(negedge GCLK);
            #1;
            if (!RSTN) begin
                pw = 1'b0;
                pc = 0;
            end else begin
                if (pw) begin
                    check("offer_held", cfg_valid, 1);
                    check("offer_step_stable", cfg_step, ps);
                end
                if (cfg_valid) check("gen_off_in_load", gen_en, 0);
                if (gen_en && gen_cycle_done) pc++;
                if (cfg_valid && cfg_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_cfg: step %0h offered, none expected", cfg_step);
                    end else begin
                        e = exp_q.pop_front();
                        check("cfg_step", cfg_step, e.step);
                        if (e.pulses >= 0) check("pulses_per_entry", pc, e.pulses);
                    end
                    pc = 0;
                end
                pw = cfg_valid && !cfg_ready;
                ps = cfg_step;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step_cycle();
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_gen_en", gen_en, 0);
        check("rst_cfg_step", cfg_step, 8'h01);
        check("rst_ld", LD, 8'h00);
        RSTN = 1'b1;
        repeat (2) step_cycle();

        // basic start with immediate ready, generator held quiet
        gen_allow = 1'b0;
        wait_max  = 0;
        start_session();
        check("start_gen_en", gen_en, 1);
        check("start_cfg_valid", cfg_valid, 0);
        check("start_ld", LD, 8'h80);

        // random sweep with one long backpressure, an ignored start and a wrap
        gen_allow = 1'b1;
        wait_max  = 3;
        bp_once   = 1'b1;
        run_until_k(2);
        hold_button(1'b1, 1'b0);
        run_until_k(NS + 1);
        stop_in_run();

        // simultaneous start and stop in idle: stop wins
        hold_button(1'b1, 1'b1);
        check("both_idle_state", LD[7:6], 0);
        check("both_cfg_valid", cfg_valid, 0);
        check("both_gen_en", gen_en, 0);

        // stop while the offer is back-pressured
        start_session();
        run_until_k(1);
        hold_ready = 1'b1;
        run_until_k(2);
        repeat (2) step_cycle();
        m_stopping = 1'b1;
        hold_button(1'b0, 1'b1);
        check("load_stop_valid", cfg_valid, 1);
        check("load_stop_gen_en", gen_en, 0);
        check("load_stop_state", LD[7:6], 1);
        check("load_stop_step", cfg_step, ref_step(m_k));
        gen_allow  = 1'b0;
        hold_ready = 1'b0;
        wait_run();
        check("load_drain_state", LD[7:6], 3);
        finish_drain();

        // asynchronous reset in the middle of a run
        start_session();
        run_until_k(1);
        wait_run();
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_gen_en", gen_en, 0);
        check("arst_ld", LD, 8'h00);
        check("arst_cfg_valid", cfg_valid, 0);
        check("arst_cfg_step", cfg_step, 8'h01);
        exp_q.delete();
        m_active = 1'b0;
        repeat (2) step_cycle();
        RSTN = 1'b1;
        repeat (3) step_cycle();
        check("post_rst_ld", LD, 8'h00);

        // fresh session after reset
        gen_allow = 1'b1;
        wait_max  = 2;
        start_session();
        run_until_k(NS + 2);
        stop_in_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tri_sweep_seq.md
TRI_SWEEP_SEQ -- requirements
Module: tri_sweep_seq

Interface
REQ-001 Parameter NUM_STEPS, default 4, number of sweep entries (2..8).
REQ-002 Parameter CYCLES_PER_STEP, default 8, triangle periods played per entry (1..255).
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, button stable time in GCLK cycles.
REQ-004 GCLK  input  1  system clock; all flops on rising edge.
REQ-005 RSTN  input  1  asynchronous active-low reset.
REQ-006 BTNU  input  1  start button, asynchronous.
REQ-007 BTND  input  1  stop button, asynchronous.
REQ-008 cfg_valid  output  1  configuration offer to the triangle generator.
REQ-009 cfg_ready  input  1  generator accepts the configuration.
REQ-010 cfg_step  output  8  per-sample increment for the current entry.
REQ-011 gen_en  output  1  generator run enable.
REQ-012 gen_cycle_done  input  1  one-cycle pulse at the end of each triangle period (output back at 0).
REQ-013 LD  output  8  status LEDs.

Function
REQ-014 The block SHALL pass BTNU and BTND through a 2-flop synchronizer, then a rising-edge detector; the result is start_p and stop_p (one-cycle pulses).
REQ-015 FSM states: IDLE, LOAD, RUN, DRAIN.
REQ-016 IDLE: gen_en=0 and cfg_valid=0; on start_p it SHALL set idx=0 and enter LOAD.
REQ-017 LOAD: cfg_valid=1 and cfg_step=1<<idx; gen_en=0.
REQ-018 LOAD: cfg_valid and cfg_step SHALL hold stable until the cycle where cfg_valid&&cfg_ready.
REQ-019 LOAD handshake cycle: enter RUN and clear cyc_cnt; gen_en=1 from the next cycle.
REQ-020 RUN: gen_en=1; each gen_cycle_done SHALL increment cyc_cnt (8 bits).
REQ-021 RUN, gen_cycle_done with cyc_cnt==CYCLES_PER_STEP-1: set idx=(idx+1) mod NUM_STEPS, go to LOAD; wrap from NUM_STEPS-1 to 0 is continuous.
REQ-022 stop_p SHALL set a sticky stop_pend flag, honoured in every state; stop_pend is cleared on entry to IDLE.
REQ-023 With stop_pend in RUN, the block SHALL enter DRAIN.
REQ-024 With stop_pend in LOAD, the block SHALL keep offering until the handshake completes, then enter DRAIN (never abandons cfg_valid).
REQ-025 DRAIN: gen_en=1 until the next gen_cycle_done, then IDLE with gen_en=0 the following cycle.
REQ-026 gen_cycle_done in the same cycle as entry to DRAIN SHALL complete the drain immediately.
REQ-027 start_p outside IDLE SHALL be ignored.
REQ-028 start_p and stop_p in the same cycle in IDLE: stop wins, and the block stays in IDLE.
REQ-029 gen_cycle_done in IDLE or LOAD SHALL be ignored.
REQ-030 LD[7:6]=state encoding (IDLE=0, LOAD=1, RUN=2, DRAIN=3); LD[5:3]=idx; LD[2:0]=cyc_cnt[2:0]; all registered.

Reset
REQ-031 RSTN low SHALL asynchronously force: state=IDLE, idx=0, cyc_cnt=0, stop_pend=0, synchronizer and debounce flops=0, cfg_valid=0, gen_en=0, cfg_step=8'h01, LD=8'h00.
REQ-032 Reset mid-operation SHALL drop gen_en and cfg_valid in the same instant, with no handshake completion.
REQ-033 Reset release SHALL be followed by normal operation from the first GCLK edge.

Configuration
REQ-034 Macro TRI_SWEEP_DEBOUNCE_EN.
REQ-035 When defined, each synchronized button SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples (counter per button), before edge detection.
REQ-036 When undefined, the synchronizer feeds the edge detector directly, and DEBOUNCE_CYCLES is unused.

Verification
REQ-037 Basic start: RSTN released, BTNU 0->1, cfg_ready=1 -> cfg_valid for 1 cycle with cfg_step=8'h01, gen_en=1 one cycle later, LD[7:6]=2.
REQ-038 Step advance: CYCLES_PER_STEP=8, 8 gen_cycle_done pulses -> LOAD with cfg_step=8'h02; after 4 entries, cfg_step returns to 8'h01.
REQ-039 Backpressure: cfg_ready held 0 for 20 cycles -> cfg_valid=1 and cfg_step stable throughout; gen_en=0 until ready.
REQ-040 Stop in RUN: BTND pulse -> gen_en stays 1 until the next gen_cycle_done, then 0; LD[7:6]=0.
REQ-041 Stop during LOAD with cfg_ready=0 -> after ready, one period in DRAIN, then IDLE.
REQ-042 Async reset asserted mid-RUN between clock edges -> gen_en=0 and LD=8'h00 before the next GCLK edge.
